// File: rtl/rtc_bus_arbiter_pkg.sv
// rtc_bus_arbiter_pkg: shared state encodings, requester indices, defaults and arbitration helper
package rtc_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam logic [1:0]  REQ_INIT     = 2'd0;
    localparam logic [1:0]  REQ_WR       = 2'd1;
    localparam logic [1:0]  REQ_RD       = 2'd2;
    localparam logic [11:0] TIMEOUT_DEF  = 12'h0FF;
    localparam logic [3:0]  STARVE_DEF   = 4'd8;

    // req0 always wins; a starved req2 jumps ahead of req1
    function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic promote);
        return req[0] ? REQ_INIT : (req[2] && promote) ? REQ_RD : req[1] ? REQ_WR : REQ_RD;
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_timer.sv
// rtc_arb_timer: counts WAIT cycles and flags the cycle on which the limit is reached
module rtc_arb_timer
    import rtc_bus_arbiter_pkg::*;
#(
    parameter logic [11:0] LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [11:0] cnt_q, cnt_d;

    // cnt_q holds the number of WAIT cycles already elapsed before the current one
    always_comb begin
        cnt_d = clear ? 12'h000 : en ? cnt_q + 12'h001 : cnt_q;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 12'h000;
        else       cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == LIMIT - 12'h001);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: three-requester arbiter in front of the RTC bus engine with timeout and req2 anti-starvation
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter logic [11:0] TIMEOUT      = TIMEOUT_DEF,
    parameter logic [3:0]  STARVE_LIMIT = STARVE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] we,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] addr2,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] wdata2,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       busy,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata
);

    state_e     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [2:0] done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       bus_req_q, bus_req_d;
    logic       bus_we_q, bus_we_d;
    logic [7:0] bus_addr_q, bus_addr_d;
    logic [7:0] bus_wdata_q, bus_wdata_d;
    logic [3:0] starve_q, starve_d;
    logic [1:0] win;
    logic       promote;
    logic       expired;

    assign promote = starve_q == STARVE_LIMIT;
    assign win     = pick_winner(req, promote);

    rtc_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .en      (state_q == ST_WAIT),
        .expired (expired)
    );

    // next-state and registered-output logic; the grant register doubles as the latched winner
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        starve_d    = starve_q;
        unique case (state_q)
            ST_IDLE: begin
                starve_d = (!req[2] || win == REQ_RD) ? 4'd0 : promote ? starve_q : starve_q + 4'd1;
                if (|req) begin
                    state_d     = ST_ISSUE;
                    gnt_d       = 3'b001 << win;
                    bus_req_d   = 1'b1;
                    bus_we_d    = we[win];
                    bus_addr_d  = win == REQ_INIT ? addr0 : win == REQ_WR ? addr1 : addr2;
                    bus_wdata_d = win == REQ_INIT ? wdata0 : win == REQ_WR ? wdata1 : wdata2;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus_done || expired) begin
                    state_d     = ST_RELEASE;
                    done_d      = gnt_q;
                    err_d       = !bus_done;
                    rdata_d     = (bus_done && !bus_we_q) ? bus_rdata : rdata_q;
                    gnt_d       = 3'b000;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 8'h00;
                    bus_wdata_d = 8'h00;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 8'h00;
            bus_wdata_q <= 8'h00;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            starve_q    <= starve_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed scoreboard bench for the RTC bus arbiter
module tb_rtc_bus_arbiter;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req, we;
    logic [7:0] addr0, addr1, addr2, wdata0, wdata1, wdata2;
    logic [2:0] gnt, done;
    logic [7:0] rdata;
    logic       err, busy, bus_req, bus_we;
    logic [7:0] bus_addr, bus_wdata;
    logic       bus_done;
    logic [7:0] bus_rdata;

    typedef struct {
        logic [2:0] gnt;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    bit         seen;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] rd_model = 8'h00;

    rtc_bus_arbiter #(.TIMEOUT(12'h010), .STARVE_LIMIT(4'd8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .wdata2    (wdata2),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_done  (bus_done),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{g, w, a, d});
    endtask

    task automatic wait_req(output bit s);
        s = 1'b0;
        for (int i = 0; i < 12 && !s; i++) begin
            @(negedge clk);
            s = bus_req;
        end
        chk("bus_req_seen", 32'(s), 32'd1);
    endtask

    // d >= 1: bus_done in WAIT cycle d; d < 1: no bus_done (timeout)
    task automatic run_txn(input int d, input logic [7:0] rd, input bit hold);
        exp_t x;
        bit   s;
        int   n;
        wait_req(s);
        if (!s) return;
        x = exp_q.pop_front();
        if (!hold) req = 3'b000;
        chk("gnt_issue", 32'(gnt), 32'(x.gnt));
        chk("bus_we", 32'(bus_we), 32'(x.we));
        chk("bus_addr", 32'(bus_addr), 32'(x.addr));
        chk("bus_wdata", 32'(bus_wdata), 32'(x.wdata));
        chk("busy_issue", 32'(busy), 32'd1);
        s = 1'b0;
        n = 0;
        while (!s && n < 40) begin
            @(negedge clk);
            n++;
            s = done != 3'b000;
            bus_done = (n == d);
            bus_rdata = rd;
        end
        bus_done = 1'b0;
        chk("done_seen", 32'(s), 32'd1);
        if (!s) return;
        chk("done_latency", 32'(n), 32'(d >= 1 ? d + 1 : TO + 1));
        chk("done_vec", 32'(done), 32'(x.gnt));
        chk("err", 32'(err), 32'(d < 1));
        if (d >= 1 && !x.we) rd_model = rd;
        chk("rdata", 32'(rdata), 32'(rd_model));
        chk("gnt_release", 32'(gnt), 32'd0);
        chk("bus_req_release", 32'(bus_req), 32'd0);
        chk("bus_addr_release", 32'(bus_addr), 32'd0);
        chk("bus_wdata_release", 32'(bus_wdata), 32'd0);
        chk("busy_release", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req = 3'b000;
        we = 3'b000;
        addr0 = 8'h10; addr1 = 8'h21; addr2 = 8'h3A;
        wdata0 = 8'hA0; wdata1 = 8'h15; wdata2 = 8'hC2;
        bus_done = 1'b0;
        bus_rdata = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single user write, bus_done three cycles after bus_req
        we = 3'b010; req = 3'b010;
        push(3'b010, 1'b1, 8'h21, 8'h15);
        run_txn(3, 8'h00, 1'b0);

        // read from requester 2
        we = 3'b000; req = 3'b100;
        push(3'b100, 1'b0, 8'h3A, 8'hC2);
        run_txn(2, 8'h59, 1'b0);

        // minimum-spacing write from requester 0; rdata must hold 8'h59
        we = 3'b001; req = 3'b001;
        push(3'b001, 1'b1, 8'h10, 8'hA0);
        run_txn(1, 8'hEE, 1'b0);

        // all three held: req0 wins, starvation builds up behind it
        we = 3'b111; req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            push(3'b001, 1'b1, 8'h10, 8'hA0);
            run_txn(1, 8'h00, 1'b1);
        end
        req = 3'b110;
        for (int i = 0; i < 5; i++) begin
            push(3'b010, 1'b1, 8'h21, 8'h15);
            run_txn(1, 8'h00, 1'b1);
        end
        push(3'b100, 1'b1, 8'h3A, 8'hC2);
        run_txn(1, 8'h00, 1'b1);
        push(3'b010, 1'b1, 8'h21, 8'h15);
        run_txn(1, 8'h00, 1'b0);

        // req2 low for one IDLE cycle clears starvation: 8 grants to 1, then 1 to 2
        @(negedge clk);
        req = 3'b110;
        for (int i = 0; i < 8; i++) begin
            push(3'b010, 1'b1, 8'h21, 8'h15);
            run_txn(1, 8'h00, 1'b1);
        end
        push(3'b100, 1'b1, 8'h3A, 8'hC2);
        run_txn(1, 8'h00, 1'b0);

        // timeout on a read: err with done, rdata unchanged
        we = 3'b000; req = 3'b010;
        push(3'b010, 1'b0, 8'h21, 8'h15);
        run_txn(-1, 8'hEE, 1'b0);

        // bus_done lands on the expiry cycle: done wins, no err
        req = 3'b100;
        push(3'b100, 1'b0, 8'h3A, 8'hC2);
        run_txn(TO, 8'hA7, 1'b0);

        // bus_done in IDLE is ignored
        bus_done = 1'b1;
        bus_rdata = 8'h77;
        @(negedge clk);
        bus_done = 1'b0;
        chk("idle_bus_done_done", 32'(done), 32'd0);
        chk("idle_bus_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_bus_done_rdata", 32'(rdata), 32'(rd_model));

        // reset during WAIT
        req = 3'b001;
        push(3'b001, 1'b0, 8'h10, 8'hA0);
        wait_req(seen);
        if (seen) begin
            e = exp_q.pop_front();
            chk("mid_gnt", 32'(gnt), 32'(e.gnt));
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
        chk("mid_busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        rd_model = 8'h00;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);

        // new request after reset is served normally
        req = 3'b010;
        push(3'b010, 1'b0, 8'h21, 8'h15);
        run_txn(1, 8'h3C, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
